// File: rtl/ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_seq
// Purpose  : Multi-cycle fetch/execute sequencer that feeds a 4-bit register
//            file. It holds the program counter, addresses an external
//            combinational instruction ROM, then latches and decodes 8-bit
//            instructions. It drives the register-file selects, write enable
//            and write data. Write data is taken from the ALU result, from
//            read port B (MOV) or from an immediate operand (LDI).
// Optional : `define CTRL_SEQ_STEP_EN adds input step_req. FETCH then waits
//            for step_req=1, so one instruction runs per step_req pulse.
//            When the macro is undefined the sequencer free-runs.
// Ports    :
//   clk       in   1     system clock, rising edge
//   rst_n     in   1     asynchronous active-low reset
//   step_req  in   1     single-step request (CTRL_SEQ_STEP_EN only)
//   INSTR     in   8     ROM data for address PC_OUT, same cycle
//   PC_OUT    out  PC_W  program counter / ROM address
//   OUT_B     in   4     register file read port B (MOV source)
//   ALU_RES   in   4     ALU result
//   ALU_Z     in   1     ALU zero indication for ALU_RES
//   ALU_OP    out  3     ALU operation (IR[6:4])
//   SEL_A     out  2     read select A  (IR[3:2])
//   SEL_B     out  2     read select B  (IR[1:0])
//   SEL_W     out  2     write select   (IR[3:2])
//   write_en  out  1     register write enable, write at the edge ending EXEC
//   DATA_OUT  out  4     register write data (0 outside EXEC)
//   z_flag    out  1     registered zero flag
//   halted    out  1     high while in HALT
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_seq #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef CTRL_SEQ_STEP_EN
    input  logic            step_req,
`endif
    input  logic [7:0]      INSTR,
    output logic [PC_W-1:0] PC_OUT,
    input  logic [3:0]      OUT_B,
    input  logic [3:0]      ALU_RES,
    input  logic            ALU_Z,
    output logic [2:0]      ALU_OP,
    output logic [1:0]      SEL_A,
    output logic [1:0]      SEL_B,
    output logic [1:0]      SEL_W,
    output logic            write_en,
    output logic [3:0]      DATA_OUT,
    output logic            z_flag,
    output logic            halted
);

    // ------------------------------------------------------------------
    // Opcodes (IR[7:4])
    // ------------------------------------------------------------------
    localparam logic [3:0] c_OP_NOP  = 4'h0;
    localparam logic [3:0] c_OP_MOV  = 4'h1;
    localparam logic [3:0] c_OP_ADD  = 4'h2;
    localparam logic [3:0] c_OP_SUB  = 4'h3;
    localparam logic [3:0] c_OP_AND  = 4'h4;
    localparam logic [3:0] c_OP_OR   = 4'h5;
    localparam logic [3:0] c_OP_XOR  = 4'h6;
    localparam logic [3:0] c_OP_NOT  = 4'h7;
    localparam logic [3:0] c_OP_LDI  = 4'h8;
    localparam logic [3:0] c_OP_JMP  = 4'h9;
    localparam logic [3:0] c_OP_JZ   = 4'hA;
    localparam logic [3:0] c_OP_HALT = 4'hB;

    localparam logic [PC_W-1:0] c_PC_ONE = PC_W'(1);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_FETCH2 = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_ir;
    logic [7:0]      r_opr;
    logic            r_z;
    logic            r_halted;
    logic            r_we;

    logic [3:0]      w_op;
    logic            w_step;
    logic            w_unused_opr;

    assign w_op = r_ir[7:4];

`ifdef CTRL_SEQ_STEP_EN
    assign w_step = step_req;
`else
    assign w_step = 1'b1;
`endif

    // Only the low bits of the operand feed the PC and LDI data; the upper
    // bits are kept in the register for completeness of the latched word.
    assign w_unused_opr = ^r_opr;

    // ------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------
    function automatic logic f_two_word(input logic [3:0] op);
        return (op == c_OP_LDI) || (op == c_OP_JMP) || (op == c_OP_JZ);
    endfunction

    function automatic logic f_writes(input logic [3:0] op);
        return (op >= c_OP_MOV) && (op <= c_OP_LDI);
    endfunction

    function automatic logic f_sets_z(input logic [3:0] op);
        return (op >= c_OP_ADD) && (op <= c_OP_NOT);
    endfunction

    // ------------------------------------------------------------------
    // Sequencer FSM
    // write_en is computed on entry to EXEC so that it is a clean register
    // output that is high exactly for the EXEC cycle of a writing opcode.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_FETCH;
            r_pc     <= '0;
            r_ir     <= 8'h00;
            r_opr    <= 8'h00;
            r_z      <= 1'b0;
            r_halted <= 1'b0;
            r_we     <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_step) begin
                        r_ir <= INSTR;
                        r_pc <= r_pc + c_PC_ONE;
                        if (f_two_word(INSTR[7:4])) begin
                            r_state <= ST_FETCH2;
                        end else begin
                            r_state <= ST_EXEC;
                            r_we    <= f_writes(INSTR[7:4]);
                        end
                    end
                end

                ST_FETCH2: begin
                    r_opr   <= INSTR;
                    r_pc    <= r_pc + c_PC_ONE;
                    r_state <= ST_EXEC;
                    r_we    <= f_writes(w_op);
                end

                ST_EXEC: begin
                    r_we <= 1'b0;
                    if (f_sets_z(w_op)) begin
                        r_z <= ALU_Z;
                    end
                    // JZ looks at the flag as it stood before this EXEC;
                    // the PC already points past the operand word when
                    // the branch is not taken.
                    case (w_op)
                        c_OP_JMP: begin
                            r_pc    <= r_opr[PC_W-1:0];
                            r_state <= ST_FETCH;
                        end
                        c_OP_JZ: begin
                            if (r_z) begin
                                r_pc <= r_opr[PC_W-1:0];
                            end
                            r_state <= ST_FETCH;
                        end
                        c_OP_HALT: begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end
                        default: begin
                            r_state <= ST_FETCH;
                        end
                    endcase
                end

                ST_HALT: begin
                    // Absorbing until reset.
                    r_state  <= ST_HALT;
                    r_halted <= 1'b1;
                    r_we     <= 1'b0;
                end

                default: begin
                    r_state <= ST_FETCH;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write data mux. Selection depends only on state and IR; the data
    // itself comes from the live register-file / ALU inputs during EXEC.
    // ------------------------------------------------------------------
    always_comb begin
        DATA_OUT = 4'd0;
        if (r_state == ST_EXEC) begin
            case (w_op)
                c_OP_MOV: DATA_OUT = OUT_B;
                c_OP_ADD,
                c_OP_SUB,
                c_OP_AND,
                c_OP_OR,
                c_OP_XOR,
                c_OP_NOT: DATA_OUT = ALU_RES;
                c_OP_LDI: DATA_OUT = r_opr[3:0];
                default:  DATA_OUT = 4'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign PC_OUT   = r_pc;
    assign ALU_OP   = r_ir[6:4];
    assign SEL_A    = r_ir[3:2];
    assign SEL_B    = r_ir[1:0];
    assign SEL_W    = r_ir[3:2];
    assign write_en = r_we;
    assign z_flag   = r_z;
    assign halted   = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_seq
// Purpose  : Self-checking bench for ctrl_seq. A behavioural ROM feeds INSTR
//            from PC_OUT. Each scenario pushes the register writes it expects
//            into a queue; a monitor pops and compares them whenever the DUT
//            asserts write_en. Timing/state checks are made inline per task.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_seq;

    localparam int PC_W = 4;

    logic            clk;
    logic            rst_n;
    logic [7:0]      INSTR;
    logic [PC_W-1:0] PC_OUT;
    logic [3:0]      OUT_B;
    logic [3:0]      ALU_RES;
    logic            ALU_Z;
    logic [2:0]      ALU_OP;
    logic [1:0]      SEL_A;
    logic [1:0]      SEL_B;
    logic [1:0]      SEL_W;
    logic            write_en;
    logic [3:0]      DATA_OUT;
    logic            z_flag;
    logic            halted;
`ifdef CTRL_SEQ_STEP_EN
    logic            step_req;
    initial step_req = 1'b1;
`endif

    logic [7:0] rom [16];
    assign INSTR = rom[PC_OUT];

    ctrl_seq #(.PC_W(PC_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef CTRL_SEQ_STEP_EN
        .step_req (step_req),
`endif
        .INSTR    (INSTR),
        .PC_OUT   (PC_OUT),
        .OUT_B    (OUT_B),
        .ALU_RES  (ALU_RES),
        .ALU_Z    (ALU_Z),
        .ALU_OP   (ALU_OP),
        .SEL_A    (SEL_A),
        .SEL_B    (SEL_B),
        .SEL_W    (SEL_W),
        .write_en (write_en),
        .DATA_OUT (DATA_OUT),
        .z_flag   (z_flag),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;
    bit  scb_on      = 1'b0;

    // Scoreboard monitor: every asserted write must match the next expected.
    always @(negedge clk) begin
        wr_t e;
        if (scb_on && rst_n && write_en) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got sel_w=%0d data=%0h, want no write",
                         SEL_W, DATA_OUT);
            end else begin
                e = exp_q.pop_front();
                if (SEL_W !== e.sel || DATA_OUT !== e.data) begin
                    miscompares++;
                    $display("FAIL write_data: got sel_w=%0d data=%0h, want sel_w=%0d data=%0h",
                             SEL_W, DATA_OUT, e.sel, e.data);
                end
            end
        end
    end

    // Hold the DUT in reset and fill the ROM with HALT so stray fetches stop.
    task automatic hold_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) rom[i] = 8'hB0;
    endtask

    // Release at a negedge; the next rising edge performs FETCH of address 0.
    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_q_empty(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_pending_writes: got %0d outstanding, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        scb_on = 1'b0;
        hold_reset();
        rom[0] = 8'h26;                       // ADD R1,R2
        ALU_RES = 4'h5; ALU_Z = 1'b1; OUT_B = 4'h0;
        vectors++;
        if (PC_OUT !== 4'd0 || write_en !== 1'b0 || z_flag !== 1'b0 ||
            halted !== 1'b0 || SEL_A !== 2'd0 || DATA_OUT !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state: got pc=%0d we=%b z=%b h=%b sa=%0d d=%0h, want all 0",
                     PC_OUT, write_en, z_flag, halted, SEL_A, DATA_OUT);
        end
        release_reset();
        @(negedge clk);                       // EXEC of ADD
        vectors++;
        if (write_en !== 1'b1 || PC_OUT !== 4'd1) begin
            miscompares++;
            $display("FAIL reset_pre_exec: got we=%b pc=%0d, want we=1 pc=1", write_en, PC_OUT);
        end
        #2 rst_n = 1'b0;                      // mid-EXEC, before the write edge
        #1;
        vectors++;
        if (write_en !== 1'b0 || PC_OUT !== 4'd0 || DATA_OUT !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_async: got we=%b pc=%0d d=%0h, want we=0 pc=0 d=0",
                     write_en, PC_OUT, DATA_OUT);
        end
        @(negedge clk);
        vectors++;
        if (z_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_zflag: got %b want 0", z_flag);
        end
        rst_n = 1'b1;
        vectors++;
        if (PC_OUT !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_first_fetch: got pc=%0d want 0", PC_OUT);
        end
        @(negedge clk);
        vectors++;
        if (PC_OUT !== 4'd1 || write_en !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_refetch: got pc=%0d we=%b, want pc=1 we=1", PC_OUT, write_en);
        end
        hold_reset();
        scb_on = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_ldi();
        hold_reset();
        rom[0] = 8'h82; rom[1] = 8'h0A;       // LDI R0,0xA
        exp_q.push_back('{sel: 2'd0, data: 4'hA});
        release_reset();
        @(negedge clk);                       // FETCH2
        vectors++;
        if (PC_OUT !== 4'd1 || write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL ldi_fetch2: got pc=%0d we=%b, want pc=1 we=0", PC_OUT, write_en);
        end
        @(negedge clk);                       // EXEC (cycle 3)
        vectors++;
        if (write_en !== 1'b1 || SEL_W !== 2'd0 || DATA_OUT !== 4'hA) begin
            miscompares++;
            $display("FAIL ldi_exec: got we=%b sw=%0d d=%0h, want we=1 sw=0 d=a",
                     write_en, SEL_W, DATA_OUT);
        end
        @(negedge clk);                       // next FETCH
        vectors++;
        if (PC_OUT !== 4'd2 || write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL ldi_next_pc: got pc=%0d we=%b, want pc=2 we=0", PC_OUT, write_en);
        end
        cycles(3);
        check_q_empty("ldi");
    endtask

    // ------------------------------------------------------------------
    task automatic test_alu_jz(input bit zero);
        logic [3:0] res;
        logic [3:0] want_pc;
        res     = zero ? 4'h0 : 4'h3;
        want_pc = zero ? 4'd5 : 4'd3;
        hold_reset();
        rom[0] = 8'h26;                       // ADD R1,R2
        rom[1] = 8'hA0; rom[2] = 8'h05;       // JZ 5
        ALU_RES = res; ALU_Z = zero;
        exp_q.push_back('{sel: 2'd1, data: res});
        release_reset();
        @(negedge clk);                       // EXEC ADD
        vectors++;
        if (SEL_A !== 2'd1 || SEL_B !== 2'd2 || ALU_OP !== 3'b010 ||
            write_en !== 1'b1 || DATA_OUT !== res) begin
            miscompares++;
            $display("FAIL add_exec: got sa=%0d sb=%0d op=%0d we=%b d=%0h, want 1 2 2 1 %0h",
                     SEL_A, SEL_B, ALU_OP, write_en, DATA_OUT, res);
        end
        @(negedge clk);                       // FETCH JZ
        vectors++;
        if (z_flag !== zero || PC_OUT !== 4'd1) begin
            miscompares++;
            $display("FAIL add_zflag: got z=%b pc=%0d, want z=%b pc=1", z_flag, PC_OUT, zero);
        end
        ALU_Z = ~zero;                        // JZ must neither sample nor update from ALU_Z
        cycles(2);                            // FETCH2, EXEC
        vectors++;
        if (PC_OUT !== 4'd3 || write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL jz_exec: got pc=%0d we=%b, want pc=3 we=0", PC_OUT, write_en);
        end
        @(negedge clk);                       // following FETCH
        vectors++;
        if (PC_OUT !== want_pc || z_flag !== zero) begin
            miscompares++;
            $display("FAIL jz_target: got pc=%0d z=%b, want pc=%0d z=%b",
                     PC_OUT, z_flag, want_pc, zero);
        end
        cycles(3);
        check_q_empty("jz");
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        hold_reset();
        rom[0] = 8'h1B;                       // MOV R2,R3
        rom[1] = 8'h74;                       // NOT R1
        rom[2] = 8'hC5;                       // reserved -> NOP
        rom[3] = 8'h4F;                       // AND R3,R3
        OUT_B = 4'h7; ALU_RES = 4'h9; ALU_Z = 1'b1;
        exp_q.push_back('{sel: 2'd2, data: 4'h7});
        exp_q.push_back('{sel: 2'd1, data: 4'h9});
        exp_q.push_back('{sel: 2'd3, data: 4'h9});
        release_reset();
        cycles(2);                            // MOV EXEC, then FETCH
        vectors++;
        if (z_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL mov_keeps_z: got %b want 0", z_flag);
        end
        cycles(2);                            // NOT EXEC, then FETCH
        vectors++;
        if (z_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL not_sets_z: got %b want 1", z_flag);
        end
        @(negedge clk);                       // EXEC of 0xC5
        vectors++;
        if (write_en !== 1'b0 || DATA_OUT !== 4'd0) begin
            miscompares++;
            $display("FAIL nop_c_exec: got we=%b d=%0h, want we=0 d=0", write_en, DATA_OUT);
        end
        @(negedge clk);                       // FETCH AND
        ALU_Z = 1'b0;
        @(negedge clk);                       // EXEC AND
        vectors++;
        if (SEL_A !== 2'd3 || SEL_B !== 2'd3 || ALU_OP !== 3'b100 || write_en !== 1'b1) begin
            miscompares++;
            $display("FAIL and_exec: got sa=%0d sb=%0d op=%0d we=%b, want 3 3 4 1",
                     SEL_A, SEL_B, ALU_OP, write_en);
        end
        @(negedge clk);
        vectors++;
        if (z_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL and_clears_z: got %b want 0", z_flag);
        end
        cycles(3);
        check_q_empty("b2b");
    endtask

    // ------------------------------------------------------------------
    task automatic test_wrap_jmp();
        hold_reset();
        rom[0]  = 8'h90; rom[1]  = 8'h0E;     // JMP 14
        rom[14] = 8'h90; rom[15] = 8'h03;     // JMP 3, straddling the wrap
        release_reset();
        cycles(3);                            // FETCH2, EXEC, FETCH @14
        vectors++;
        if (PC_OUT !== 4'd14) begin
            miscompares++;
            $display("FAIL jmp_to_14: got pc=%0d want 14", PC_OUT);
        end
        @(negedge clk);                       // FETCH2 reads 15
        vectors++;
        if (PC_OUT !== 4'd15 || INSTR !== 8'h03) begin
            miscompares++;
            $display("FAIL wrap_fetch2: got pc=%0d instr=%0h, want pc=15 instr=03", PC_OUT, INSTR);
        end
        @(negedge clk);                       // EXEC, PC wrapped
        vectors++;
        if (PC_OUT !== 4'd0) begin
            miscompares++;
            $display("FAIL wrap_pc: got pc=%0d want 0", PC_OUT);
        end
        @(negedge clk);
        vectors++;
        if (PC_OUT !== 4'd3) begin
            miscompares++;
            $display("FAIL wrap_jmp_target: got pc=%0d want 3", PC_OUT);
        end
        cycles(3);
    endtask

    task automatic test_nop_wrap();
        hold_reset();
        rom[0]  = 8'h90; rom[1] = 8'h0F;      // JMP 15
        rom[15] = 8'h00;                      // NOP
        release_reset();
        cycles(3);
        vectors++;
        if (PC_OUT !== 4'd15) begin
            miscompares++;
            $display("FAIL nop_at_15: got pc=%0d want 15", PC_OUT);
        end
        cycles(2);                            // NOP EXEC, next FETCH
        vectors++;
        if (PC_OUT !== 4'd0 || write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL nop_wrap: got pc=%0d we=%b, want pc=0 we=0", PC_OUT, write_en);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_halt();
        hold_reset();
        rom[0] = 8'hB0;
        release_reset();
        @(negedge clk);                       // EXEC of HALT
        vectors++;
        if (halted !== 1'b0 || write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_exec: got h=%b we=%b, want h=0 we=0", halted, write_en);
        end
        @(negedge clk);
        vectors++;
        if (halted !== 1'b1 || PC_OUT !== 4'd1) begin
            miscompares++;
            $display("FAIL halt_enter: got h=%b pc=%0d, want h=1 pc=1", halted, PC_OUT);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (PC_OUT !== 4'd1 || write_en !== 1'b0 || halted !== 1'b1) begin
                miscompares++;
                $display("FAIL halt_hold[%0d]: got pc=%0d we=%b h=%b, want pc=1 we=0 h=1",
                         i, PC_OUT, write_en, halted);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (halted !== 1'b0 || PC_OUT !== 4'd0) begin
            miscompares++;
            $display("FAIL halt_reset: got h=%b pc=%0d, want h=0 pc=0", halted, PC_OUT);
        end
        release_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        OUT_B = 4'h0; ALU_RES = 4'h0; ALU_Z = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 8'hB0;
        cycles(2);
        test_reset();
        test_ldi();
        test_alu_jz(1'b1);
        test_alu_jz(1'b0);
        test_back_to_back();
        test_wrap_jmp();
        test_nop_wrap();
        test_halt();
        check_q_empty("final");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Multi-cycle fetch/execute sequencer that sits directly upstream of the 4-bit register file.
- Holds the program counter and addresses an external combinational instruction ROM.
- Latches and decodes 8-bit instructions.
- Drives the register file's read selects, write select, write enable and write data. Write data comes from the ALU result, from read port B, or from an immediate.

Parameters:
- PC_W, 4, program counter and instruction ROM address width (1..8).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- INSTR  in  8  ROM data for address PC_OUT, valid in the same cycle.
- PC_OUT  out  PC_W  program counter / ROM address.
- OUT_B  in  4  register file read port B (MOV source).
- ALU_RES  in  4  ALU result.
- ALU_Z  in  1  ALU zero indication for ALU_RES.
- ALU_OP  out  3  ALU operation, equal to IR[6:4].
- SEL_A  out  2  register file read select A.
- SEL_B  out  2  register file read select B.
- SEL_W  out  2  register file write select.
- write_en  out  1  register file write enable; the write occurs at the clk edge that ends EXEC.
- DATA_OUT  out  4  register file write data.
- z_flag  out  1  registered zero flag.
- halted  out  1  high when the sequencer is in HALT.

Behaviour:
- Clocking: single clock clk; reset rst_n is asynchronous, active-low.
- Reset: PC=0, IR=0, OPR=0, z_flag=0, state=FETCH, halted=0, write_en=0. All outputs are valid immediately on rst_n assertion.
- Instruction format: IR[7:4] opcode, IR[3:2] rd, IR[1:0] rs. Two-word opcodes take an 8-bit operand word OPR from the next ROM address.
- Opcodes:
  - 0 NOP.
  - 1 MOV rd,rs: DATA_OUT=OUT_B.
  - 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR rd,rs: DATA_OUT=ALU_RES.
  - 7 NOT rd: DATA_OUT=ALU_RES.
  - 8 LDI rd,OPR: DATA_OUT=OPR[3:0].
  - 9 JMP OPR.
  - A JZ OPR.
  - B HALT.
  - C..F: treated as NOP.
- FSM states: FETCH, FETCH2, EXEC, HALT.
  - FETCH: IR<=INSTR; PC<=PC+1; next state is FETCH2 if INSTR[7:4] is 8, 9 or A, else EXEC.
  - FETCH2: OPR<=INSTR; PC<=PC+1; next state EXEC.
  - EXEC: one cycle, then FETCH. Opcode B goes to HALT instead.
  - HALT: absorbing; PC, IR and z_flag frozen, halted=1. Only rst_n exits.
- Instruction latency: single-word instructions take 2 cycles; two-word instructions take 3.
- EXEC outputs (Moore, decoded from state and IR only):
  - SEL_A=IR[3:2], SEL_B=IR[1:0], SEL_W=IR[3:2], ALU_OP=IR[6:4].
  - write_en=1 only for opcodes 1..8.
  - In all other states write_en=0 and DATA_OUT=0. SEL_A, SEL_B and SEL_W always follow IR.
- z_flag: updated at the end of EXEC from ALU_Z for opcodes 2..7 only. MOV, LDI and jumps leave it unchanged.
- Jumps (at the end of EXEC):
  - JMP: PC<=OPR[PC_W-1:0].
  - JZ: PC<=OPR[PC_W-1:0] if z_flag=1, else PC is unchanged (already points past the operand).
  - JZ tests the z_flag value held before this EXEC.
- PC arithmetic is modulo 2^PC_W. An increment from all-ones wraps to 0 in both FETCH and FETCH2, so a two-word instruction may straddle the wrap.
- Reset mid-instruction: the partially executed instruction is discarded and no register write occurs.
- There is no write/read hazard inside the block. A read of the register written in the previous EXEC sees the new value, because the register file updates at that edge.

Optional Feature:
- Macro: CTRL_SEQ_STEP_EN.
- Defined: adds input port step_req (1 bit).
  - FETCH holds (PC and IR unchanged) until step_req=1 is sampled; the transition then proceeds as normal.
  - FETCH2 and EXEC are not gated.
  - Effect: one instruction executes per step_req pulse.
- Undefined: port absent; the sequencer free-runs.

Test Plan:
- Reset during EXEC of ADD R1,R2 -> write_en falls to 0 asynchronously, PC_OUT=0, z_flag=0, no register write; after release, first FETCH is at address 0.
- ROM[0]=0x82, ROM[1]=0x0A (LDI R0? no: rd=0, rs=2; LDI R0,0xA) -> cycle 3 shows write_en=1, SEL_W=0, DATA_OUT=0xA; then PC_OUT=2 in the following FETCH.
- ADD R1,R2 (0x26) with ALU_RES=0, ALU_Z=1 -> EXEC shows SEL_A=1, SEL_B=2, ALU_OP=010, write_en=1, DATA_OUT=0; z_flag=1 afterwards.
- Next instruction JZ 0x05 (0xA0,0x05) -> PC_OUT=5 in the following FETCH.
- Repeat with ALU_Z=0 -> JZ not taken, PC_OUT=next sequential address.
- PC_W=4: JMP opcode at address 14 (0x90) with operand at 15 (0x03) -> FETCH2 reads address 15, PC wraps, and the jump lands at PC_OUT=3.
- Separately, a NOP at address 15 -> next FETCH is at address 0.
- HALT (0xB0) -> halted=1 from the cycle after EXEC; PC_OUT is constant and write_en=0 for 20 further cycles; rst_n pulse -> halted=0, PC_OUT=0.
